hit_latency_tdc: RTL and testbench



---
 rtl/afe_pkg.sv | 18 +
 rtl/sync_fifo.sv | 77 +++++++
 rtl/hit_latency_tdc.sv | 178 +++++++++++++++++
 tb/tb_hit_latency_tdc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// Shared definitions for the AFE hit-latency measurement block:
// FSM state encoding and result-word layout helpers.
package afe_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  // The MISS flag sits directly above the latency field.
  function automatic int miss_pos(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int result_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered EMPTY/FULL flags
// and a synchronous clear that overrides any concurrent write or read.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nx;
  logic             w_wr;
  logic             w_rd;

  // A full FIFO drops writes even when a read frees a slot this cycle.
  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  always_comb begin
    w_count_nx = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nx = r_count + CW'(1);
      2'b01:   w_count_nx = r_count - CW'(1);
      default: w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_clr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      o_empty   <= 1'b1;
      o_full    <= 1'b0;
      o_rd_data <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_empty  <= 1'b1;
      o_full   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        o_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nx;
      o_empty <= (w_count_nx == '0);
      o_full  <= (w_count_nx == FULL_CNT);
    end
  end

endmodule

// File: rtl/hit_latency_tdc.sv
// Measures INJ_IN-rise to HIT-rise latency in CLK cycles per injection pulse,
// queues {MISS, LATENCY} results and keeps saturating hit/miss/drop counters.
module hit_latency_tdc
  import afe_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int STAT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CLR,
  input  logic              INJ_IN,
  input  logic              HIT,
  input  logic              RD_EN,
  output logic [CNT_W:0]    RD_DATA,
  output logic              EMPTY,
  output logic              FULL,
  output logic [STAT_W-1:0] HIT_CNT,
  output logic [STAT_W-1:0] MISS_CNT,
  output logic [STAT_W-1:0] DROP_CNT
);

  localparam int RES_W    = result_w(CNT_W);
  localparam int MISS_POS = miss_pos(CNT_W);

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] lat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             r_inj_s1, r_inj_s2, r_inj_d;
  logic             r_hit_s1, r_hit_s2, r_hit_d;
  logic             w_inj_rise, w_inj_fall, w_hit_rise;
  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_lat, w_lat_nx, w_wr_lat;
  logic             w_wr, w_wr_miss, w_hit_inc, w_miss_inc, w_drop;
  logic [RES_W-1:0] w_wr_data;

  // Both inputs see an identical 2-FF delay, so edge spacing is preserved.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_inj_s1 <= 1'b0;
      r_inj_s2 <= 1'b0;
      r_inj_d  <= 1'b0;
      r_hit_s1 <= 1'b0;
      r_hit_s2 <= 1'b0;
      r_hit_d  <= 1'b0;
    end else begin
      r_inj_s1 <= INJ_IN;
      r_inj_s2 <= r_inj_s1;
      r_inj_d  <= r_inj_s2;
      r_hit_s1 <= HIT;
      r_hit_s2 <= r_hit_s1;
      r_hit_d  <= r_hit_s2;
    end
  end

  assign w_inj_rise = r_inj_s2 && !r_inj_d;
  assign w_inj_fall = !r_inj_s2 && r_inj_d;
  assign w_hit_rise = r_hit_s2 && !r_hit_d;

  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_wr       = 1'b0;
    w_wr_miss  = 1'b0;
    w_wr_lat   = r_lat;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (EN && w_inj_rise) begin
          if (w_hit_rise) begin
            w_wr       = 1'b1;
            w_wr_lat   = '0;
            w_hit_inc  = 1'b1;
            w_state_nx = ST_WAIT_LOW;
          end else begin
            w_lat_nx   = CNT_W'(1);
            w_state_nx = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (!EN) begin
          w_state_nx = ST_IDLE;
        end else if (w_hit_rise) begin
          // A hit coinciding with the injection falling edge still counts.
          w_wr       = 1'b1;
          w_hit_inc  = 1'b1;
          w_state_nx = w_inj_fall ? ST_IDLE : ST_WAIT_LOW;
        end else if (w_inj_fall) begin
          w_wr       = 1'b1;
          w_wr_miss  = 1'b1;
          w_miss_inc = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_lat_nx = lat_inc(r_lat);
        end
      end
      ST_WAIT_LOW: begin
        if (!EN || w_inj_fall) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (CLR) begin
      w_state_nx = ST_IDLE;
      w_wr       = 1'b0;
      w_hit_inc  = 1'b0;
      w_miss_inc = 1'b0;
    end
  end

  always_comb begin
    w_wr_data                = '0;
    w_wr_data[CNT_W-1:0]     = w_wr_lat;
    w_wr_data[MISS_POS]      = w_wr_miss;
  end

  assign w_drop = w_wr && FULL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge CLK) begin
    r_lat <= w_lat_nx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
      DROP_CNT <= '0;
    end else if (CLR) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
      DROP_CNT <= '0;
    end else begin
      if (w_hit_inc) begin
        HIT_CNT <= stat_inc(HIT_CNT);
      end
      if (w_miss_inc) begin
        MISS_CNT <= stat_inc(MISS_CNT);
      end
      if (w_drop) begin
        DROP_CNT <= stat_inc(DROP_CNT);
      end
    end
  end

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (CLR),
    .i_wr_en   (w_wr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (RD_EN),
    .o_rd_data (RD_DATA),
    .o_empty   (EMPTY),
    .o_full    (FULL)
  );

endmodule

// File: tb/tb_hit_latency_tdc.sv
// Bench for hit_latency_tdc: directed scenarios plus randomized injections,
// checked against a queue-based model of the measurement rules.
module tb_hit_latency_tdc;

  localparam int DEPTH = 16;
  localparam int LMAX  = 4095;
  localparam int SMAX  = 15;

  logic        CLK = 1'b0;
  logic        RST, EN, CLR, INJ_IN, HIT, RD_EN;
  logic [12:0] RD_DATA;
  logic        EMPTY, FULL;
  logic [15:0] HIT_CNT, MISS_CNT, DROP_CNT;
  logic [4:0]  s_rd_data;
  logic        s_empty, s_full;
  logic [15:0] s_hit_cnt, s_miss_cnt, s_drop_cnt;

  int checks   = 0;
  int failures = 0;
  int q[$];
  int m_hit, m_miss, m_drop, m_rd;

  hit_latency_tdc dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .INJ_IN(INJ_IN), .HIT(HIT),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL),
    .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT), .DROP_CNT(DROP_CNT)
  );

  hit_latency_tdc #(.CNT_W(4)) dut_small (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .INJ_IN(INJ_IN), .HIT(HIT),
    .RD_EN(RD_EN), .RD_DATA(s_rd_data), .EMPTY(s_empty), .FULL(s_full),
    .HIT_CNT(s_hit_cnt), .MISS_CNT(s_miss_cnt), .DROP_CNT(s_drop_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mk(input int miss, input int lat);
    return (miss << 12) | (lat > LMAX ? LMAX : lat);
  endfunction

  task automatic model_clear();
    q.delete();
    m_hit = 0; m_miss = 0; m_drop = 0;
  endtask

  task automatic model_push(input int word);
    if (q.size() < DEPTH) q.push_back(word);
    else m_drop++;
  endtask

  task automatic check_stats();
    check("hit_cnt",  32'(HIT_CNT),  32'(m_hit));
    check("miss_cnt", 32'(MISS_CNT), 32'(m_miss));
    check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
    check("empty",    32'(EMPTY),    32'(q.size() == 0));
    check("full",     32'(FULL),     32'(q.size() == DEPTH));
  endtask

  // One injection pulse w cycles wide; HIT rises d cycles after INJ_IN
  // (d<0: never). en_drop>=0 pulses EN low for one cycle at that step.
  task automatic inject(input int w, input int d, input int en_drop);
    bit en0 = EN;
    for (int i = 0; i <= w; i++) begin
      if (i == d) HIT = 1'b1;
      if (i == 0) INJ_IN = 1'b1;
      if (i == w) INJ_IN = 1'b0;
      if (i == en_drop) EN = 1'b0;
      if (en_drop >= 0 && i == en_drop + 1) EN = 1'b1;
      @(negedge CLK);
    end
    HIT = 1'b0;
    repeat (6) @(negedge CLK);
    if (en0 && en_drop < 0) begin
      if (d >= 0 && d <= w) begin
        m_hit++;
        model_push(mk(0, d));
      end else begin
        m_miss++;
        model_push(mk(1, w));
      end
    end
  endtask

  task automatic do_read();
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    if (q.size() > 0) m_rd = q.pop_front();
    check("rd_data", 32'(RD_DATA), 32'(m_rd));
    check("rd_empty", 32'(EMPTY), 32'(q.size() == 0));
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    model_clear();
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; CLR = 1'b0; INJ_IN = 1'b0; HIT = 1'b0; RD_EN = 1'b0;
    model_clear();
    m_rd = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check_stats();

    // Hit 10 cycles after injection
    inject(15, 10, -1);
    check_stats();
    do_read();

    // Miss after 20 cycles
    inject(20, -1, -1);
    check_stats();
    do_read();

    // Same-cycle rise, and hit on the injection falling edge
    inject(5, 0, -1);
    do_read();
    inject(8, 8, -1);
    check_stats();
    do_read();

    // EN low for a whole injection, then EN dropped while armed
    EN = 1'b0;
    inject(12, 6, -1);
    EN = 1'b1;
    inject(15, 10, 5);
    check_stats();

    // Latency saturation on the 4-bit instance
    do_clr();
    inject(35, 30, -1);
    check("sat_hit_small", 32'(s_hit_cnt), 32'd1);
    do_read();
    check("sat_rd_small", 32'(s_rd_data), 32'(30 > SMAX ? SMAX : 30));
    check("sat_small_miss", 32'(s_miss_cnt), 32'd0);
    check("sat_small_drop", 32'(s_drop_cnt), 32'd0);
    check("sat_small_empty", 32'(s_empty), 32'd1);
    check("sat_small_full", 32'(s_full), 32'd0);

    // Overfill: 18 hits, 2 dropped, drain in order
    for (int i = 0; i < 18; i++) inject(5 + i, 3 + i, -1);
    check_stats();
    for (int i = 0; i < 16; i++) do_read();
    do_read();
    check_stats();

    // CLR while full
    for (int i = 0; i < 17; i++) inject(4, 2, -1);
    check_stats();
    do_clr();
    check_stats();

    // RST while armed, then a clean measurement
    inject(3, 1, -1);
    INJ_IN = 1'b1;
    repeat (6) @(negedge CLK);
    RST = 1'b1; INJ_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    model_clear();
    m_rd = 0;
    check("rst_arm_rd_data", 32'(RD_DATA), 32'd0);
    check_stats();
    inject(9, 7, -1);
    check_stats();
    do_read();

    // Randomized injections with interleaved reads
    for (int n = 0; n < 40; n++) begin
      int w, d, nr;
      w  = $urandom_range(1, 25);
      d  = ($urandom % 4 == 0) ? -1 : $urandom_range(0, w + 3);
      EN = ($urandom % 8 != 0);
      inject(w, d, -1);
      EN = 1'b1;
      check_stats();
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) do_read();
    end
    while (q.size() > 0) do_read();
    do_read();
    check_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
